// File: rtl/osd_pkg.sv
// osd_pkg: shared latency, types, colours and helpers for the OSD overlay blocks.
package osd_pkg;

    localparam int OSD_LAT = 3;

    typedef logic [23:0] rgb888_t;

    localparam rgb888_t COLOR_WHITE = 24'hffffff;
    localparam rgb888_t COLOR_BLACK = 24'h000000;

    function automatic int font_aw(input int char_h);
        return 8 + $clog2(char_h);
    endfunction

endpackage

// File: rtl/osd_text_overlay_if.sv
// osd_text_overlay_if: video in/out stream plus text RAM and font ROM buses of the overlay.
interface osd_text_overlay_if #(
    parameter int ADDR_W = 8,
    parameter int CHAR_W = 8,
    parameter int FA_W   = 12
);
    logic                i_vs, i_hs, i_de;
    osd_pkg::rgb888_t    i_data;
    logic                o_vs, o_hs, o_de;
    osd_pkg::rgb888_t    o_data;
    logic                osd_enable;
    logic                text_update;
    logic                text_bank;
    logic [ADDR_W-1:0]   text_addr;
    logic [7:0]          text_data;
    logic [FA_W-1:0]     font_addr;
    logic [CHAR_W-1:0]   font_row;

    modport master (
        output i_vs, i_hs, i_de, i_data, osd_enable, text_update, text_data, font_row,
        input  o_vs, o_hs, o_de, o_data, text_bank, text_addr, font_addr
    );

    modport slave (
        input  i_vs, i_hs, i_de, i_data, osd_enable, text_update, text_data, font_row,
        output o_vs, o_hs, o_de, o_data, text_bank, text_addr, font_addr
    );
endinterface

// File: rtl/osd_pos_counter.sv
// osd_pos_counter: pixel x / line y counters with vs rising-edge detection.
module osd_pos_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_i,
    input  logic        de_i,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        vs_rise_o
);
    logic        vs_q, de_q;
    logic [11:0] x_q, y_q, x_d, y_d;

    assign vs_rise_o = vs_i & ~vs_q;

    always_comb begin
        x_d = de_i ? x_q + 12'd1 : 12'd0;
        y_d = vs_rise_o ? 12'd0 : (de_q & ~de_i) ? y_q + 12'd1 : y_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b0;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            vs_q <= vs_i;
            de_q <= de_i;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/osd_text_overlay.sv
// osd_text_overlay: COLS x ROWS text grid drawn over a 24-bit video stream, fixed 3-cycle latency.
// Define OSD_BG_BLEND_EN to darken non-glyph pixels inside the text window by 50%.
module osd_text_overlay
    import osd_pkg::*;
#(
    parameter logic [11:0] X_START  = 12'd1000,
    parameter logic [11:0] Y_START  = 12'd270,
    parameter int          COLS     = 16,
    parameter int          ROWS     = 4,
    parameter int          CHAR_W   = 8,
    parameter int          CHAR_H   = 16,
    parameter int          LINE_GAP = 8,
    parameter rgb888_t     COLOR_FG = COLOR_WHITE,
    parameter int          ADDR_W   = 8
) (
    input logic               video_clk,
    input logic               rst,
    osd_text_overlay_if.slave bus
);
    localparam int          P     = CHAR_H + LINE_GAP;
    localparam int          GL_W  = $clog2(CHAR_H);
    localparam logic [11:0] X_END = 12'(int'(X_START) + COLS * CHAR_W);
    localparam logic [11:0] Y_END = 12'(int'(Y_START) + (ROWS - 1) * P + CHAR_H);
`ifdef OSD_BG_BLEND_EN
    localparam bit BLEND = 1'b1;
`else
    localparam bit BLEND = 1'b0;
`endif

    logic [11:0]       x, y, dx, dy, col, row, ly;
    logic              vs_rise, rect, win, hit;
    logic [3:0]        px;
    logic [GL_W-1:0]   gl;
    logic              bank_q, bank_d, pend_q, pend_d, valid_q, valid_d;
    logic              win1_q, rect1_q, win2_q, rect2_q, zero2_q;
    logic [3:0]        px1_q, px2_q;
    logic [GL_W-1:0]   gl1_q;
    rgb888_t           data1_q, data2_q, o_data_q, bg;
    logic [2:0]        sync1_q, sync2_q, o_sync_q;
    logic [CHAR_W-1:0] fr_sh;

    osd_pos_counter u_pos (
        .clk      (video_clk),
        .rst      (rst),
        .vs_i     (bus.i_vs),
        .de_i     (bus.i_de),
        .x_o      (x),
        .y_o      (y),
        .vs_rise_o(vs_rise)
    );

    // S0: window decode from the position counters
    always_comb begin
        dx   = x - X_START;
        dy   = y - Y_START;
        col  = dx / 12'(CHAR_W);
        px   = 4'(dx % 12'(CHAR_W));
        row  = dy / 12'(P);
        ly   = dy % 12'(P);
        gl   = ly[GL_W-1:0];
        rect = bus.i_de & valid_q & (x >= X_START) & (x < X_END) & (y >= Y_START) & (y < Y_END);
        win  = rect & (ly < 12'(CHAR_H));
    end

    // Bank flips only at a vs edge, so one frame never mixes two texts
    always_comb begin
        bank_d  = (vs_rise & (pend_q | bus.text_update)) ? ~bank_q : bank_q;
        pend_d  = vs_rise ? 1'b0 : pend_q | bus.text_update;
        valid_d = valid_q | vs_rise;
    end

    assign bus.text_addr = ADDR_W'({11'd0, bank_q} * 12'(COLS * ROWS) + row * 12'(COLS) + col);
    assign bus.font_addr = {bus.text_data, gl1_q};

    // S2: glyph bit select, MSB of font_row is the leftmost pixel
    assign fr_sh = bus.font_row << px2_q;
    assign hit   = win2_q & ~zero2_q & fr_sh[CHAR_W-1] & bus.osd_enable;
    assign bg    = (BLEND && rect2_q && bus.osd_enable) ? (data2_q >> 1) & 24'h7f7f7f : data2_q;

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            bank_q   <= 1'b0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            win1_q   <= 1'b0;
            rect1_q  <= 1'b0;
            px1_q    <= '0;
            gl1_q    <= '0;
            data1_q  <= '0;
            sync1_q  <= '0;
            win2_q   <= 1'b0;
            rect2_q  <= 1'b0;
            px2_q    <= '0;
            zero2_q  <= 1'b0;
            data2_q  <= '0;
            sync2_q  <= '0;
            o_sync_q <= '0;
            o_data_q <= '0;
        end else begin
            bank_q   <= bank_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            win1_q   <= win;
            rect1_q  <= rect;
            px1_q    <= px;
            gl1_q    <= gl;
            data1_q  <= bus.i_data;
            sync1_q  <= {bus.i_vs, bus.i_hs, bus.i_de};
            win2_q   <= win1_q;
            rect2_q  <= rect1_q;
            px2_q    <= px1_q;
            zero2_q  <= bus.text_data == 8'd0;
            data2_q  <= data1_q;
            sync2_q  <= sync1_q;
            o_sync_q <= sync2_q;
            o_data_q <= hit ? COLOR_FG : bg;
        end
    end

    assign {bus.o_vs, bus.o_hs, bus.o_de} = o_sync_q;
    assign bus.o_data    = o_data_q;
    assign bus.text_bank = bank_q;
endmodule

// File: tb/tb_osd_text_overlay.sv
// tb_osd_text_overlay: random video frames against a coordinate-level model of the text overlay.
module tb_osd_text_overlay;
    localparam int XS = 24, YS = 6, COLS = 16, ROWS = 4, CW = 8, CH = 16, PITCH = 24;
    localparam int PIX = 152, H_TOT = 156, LINES = 96;
    localparam logic [23:0] FG = 24'hffffff;

    typedef struct {
        bit          blank;
        logic [2:0]  sync;
        logic [23:0] d;
        bit          rect;
        bit          win;
        logic [7:0]  code;
        int          gl;
        int          px;
        bit          en;
    } rec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] ram [256];
    logic [7:0] rom [4096];
    rec_t q[$];
    int n_vec = 0, n_err = 0;
    bit m_bank, m_pend, m_valid, m_vs;

    osd_text_overlay_if #(.ADDR_W(8), .CHAR_W(8), .FA_W(12)) bus ();

    osd_text_overlay #(.X_START(12'd24), .Y_START(12'd6)) dut (
        .video_clk(clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.text_data <= ram[bus.text_addr];
        bus.font_row  <= rom[bus.font_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] exp_out(input rec_t r);
        logic [7:0]  fr;
        logic [23:0] bg;
        bit          hit;
        if (r.blank) return '0;
        fr  = rom[int'(r.code) * CH + r.gl];
        hit = r.win && r.code != 8'd0 && fr[CW - 1 - r.px] && r.en;
        bg  = r.d;
`ifdef OSD_BG_BLEND_EN
        if (r.rect && r.en) bg = (r.d >> 1) & 24'h7f7f7f;
`endif
        return {r.sync, hit ? FG : bg};
    endfunction

    task automatic step(input bit vs, hs, de, input logic [23:0] d, input bit upd, en, input int x, y);
        rec_t r, t;
        int rel, a;
        @(negedge clk);
        r = q.pop_front();
        check("pix", {5'd0, bus.o_vs, bus.o_hs, bus.o_de, bus.o_data}, {5'd0, exp_out(r)});
        check("bank", {31'd0, bus.text_bank}, {31'd0, m_bank});
        bus.i_vs = vs; bus.i_hs = hs; bus.i_de = de; bus.i_data = d;
        bus.text_update = upd; bus.osd_enable = en;
        r = '{default: 0};
        r.sync = {vs, hs, de};
        r.d = d;
        rel = y - YS;
        a = 0;
        r.rect = m_valid && de && x >= XS && x < XS + COLS * CW && y >= YS && y < YS + (ROWS - 1) * PITCH + CH;
        r.win = r.rect && (rel % PITCH) < CH;
        if (r.win) begin
            a = int'(m_bank) * COLS * ROWS + (rel / PITCH) * COLS + (x - XS) / CW;
            r.code = ram[a];
            r.gl = rel % PITCH;
            r.px = (x - XS) % CW;
        end
        if (vs && !m_vs) begin
            if (m_pend || upd) m_bank = ~m_bank;
            m_pend = 0;
            m_valid = 1;
        end else m_pend = m_pend | upd;
        m_vs = vs;
        q.push_back(r);
        t = q[0];
        t.en = en;
        q[0] = t;
        if (r.win) begin
            #1;
            check("addr", {24'd0, bus.text_addr}, a);
        end
    endtask

    task automatic do_reset();
        rec_t z;
        @(negedge clk);
        rst = 1'b1;
        bus.i_vs = 0; bus.i_hs = 0; bus.i_de = 0; bus.i_data = '0; bus.text_update = 0;
        #1;
        check("rst_out", {5'd0, bus.o_vs, bus.o_hs, bus.o_de, bus.o_data}, 32'd0);
        check("rst_bank", {31'd0, bus.text_bank}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        z = '{default: 0};
        z.blank = 1;
        q.delete();
        repeat (3) q.push_back(z);
        m_bank = 0; m_pend = 0; m_valid = 0; m_vs = 0;
    endtask

    function automatic logic [23:0] rnd_pix();
        return ($urandom % 8 == 0) ? 24'h808080 : 24'($urandom);
    endfunction

    function automatic bit en_of(input int mode);
        return mode == 2 ? bit'($urandom % 2) : bit'(mode);
    endfunction

    task automatic frame(input int en_mode, input int upd_a, input int upd_b, input bit upd_vs, input int rst_line);
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < H_TOT; p++)
                step(1, p >= PIX && p < PIX + 2, 0, rnd_pix(), upd_vs && l == 0 && p == 0, en_of(en_mode), 0, 0);
        for (int l = 0; l < LINES; l++)
            for (int p = 0; p < H_TOT; p++) begin
                if (l == rst_line && p == 60) begin
                    do_reset();
                    return;
                end
                step(0, p >= PIX && p < PIX + 2, p < PIX, rnd_pix(), (l == upd_a || l == upd_b) && p == 5,
                     en_of(en_mode), p, l);
            end
    endtask

    task automatic fill_bank(input int b);
        for (int i = 0; i < COLS * ROWS; i++)
            ram[b * COLS * ROWS + i] = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
        if (b == 0) begin
            ram[0] = 8'h41;
            ram[1] = 8'h00;
        end
    endtask

    initial begin
        bus.i_vs = 0; bus.i_hs = 0; bus.i_de = 0; bus.i_data = '0;
        bus.osd_enable = 0; bus.text_update = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < CH; i++) rom[i] = 8'hff;
        rom[8'h41 * CH] = 8'h80;
        for (int i = 0; i < 256; i++) ram[i] = 8'd0;
        fill_bank(0);
        fill_bank(1);
        do_reset();
        frame(0, 40, 60, 0, -1);
        frame(1, -1, -1, 0, -1);
        fill_bank(0);
        frame(1, 30, -1, 1, -1);
        frame(2, -1, -1, 0, 50);
        frame(2, -1, -1, 0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
